seq_booth_mul: RTL and testbench
================================

Name: seq_booth_mul

Overview:
Iterative radix-4 Booth multiplier, parametrised in operand width, with a start/done handshake.
- Sequential successor to the combinational 32x32 booth_mul.
- Retires 2 multiplier bits per clock and adds a signed/unsigned mode.
- Sits in the ALU multiplier slot wherever area matters more than single-cycle latency.
- The ALU control FSM issues start, waits for done, then reads Product.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4.
ITER, WIDTH/2+1, derived localparam and not overridable; number of Booth iterations.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
A  input  WIDTH  multiplicand; captured with start
B  input  WIDTH  multiplier; captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; Product is valid in that cycle
Product  output  2*WIDTH  result; held until the next accepted start

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, Product=0.
  - All internal registers (accumulator, shifted multiplier, counter, Booth bit) are cleared.
  - An operation in flight is abandoned; no done pulse is issued for it.
- FSM states: IDLE, CALC, DONE.
  - IDLE: if start=1 at a clock edge, capture A, B and signed_mode, then go to CALC.
  - CALC: one radix-4 step per cycle. The counter runs from 0 to ITER-1; after the last step go to DONE.
  - DONE: Product gets the final 2*WIDTH accumulator bits, done=1 for exactly this one cycle, busy=0, then return to IDLE.
- Timing: start is accepted at edge T. busy=1 from T+1 through T+ITER. done=1 in cycle T+ITER+1. For WIDTH=32 that is 18 cycles from start to done.
- Operand extension: both operands are extended to WIDTH+2 bits.
  - signed_mode=1: sign-extend.
  - signed_mode=0: zero-extend. This makes unsigned full-range operands correct.
- Each step:
  - Examine the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Select a partial product from 0, +M, +2M, -M, -2M.
  - Add it to the upper half of a (2*WIDTH+4)-bit accumulator.
  - Arithmetic-shift right by 2.
  - Negation is two's complement. Accumulator arithmetic must not overflow at any width.
- Result is exact for all operand pairs in both modes; Product is the low 2*WIDTH bits.
- Start while busy or in DONE: ignored. No queueing, and the captured operands are unchanged.
- Changing A, B or signed_mode after the start is accepted has no effect on the result.
- After DONE, a start in the IDLE cycle that immediately follows is accepted, so back-to-back throughput is one result per ITER+2 cycles.
- Product keeps its last value until the DONE cycle of the next operation. It is not cleared by start.
- If start and rst are both high, reset wins.

Test Plan:
- WIDTH=32, signed: A=20, B=-3 (32'hFFFFFFFD), start. Required: done exactly 18 cycles after start, Product=64'hFFFFFFFFFFFFFFC4 (-60), busy high for 17 cycles.
- WIDTH=32, signed, back-to-back issues:
  - -90 * -90 gives 64'd8100.
  - -100 * 99 gives -64'd9900.
  - 0 * 98765 gives 0.
  - Signed corner: 32'h80000000 * 32'h80000000 gives 64'h4000000000000000.
  - Required: each Product matches, and each start is issued in the IDLE cycle after the previous done.
- WIDTH=32, unsigned: A=B=32'hFFFFFFFF. Required: Product=64'hFFFFFFFE00000001. The same operands with signed_mode=1 give 64'h0000000000000001.
- Ignored start: start a 77*88 operation, then pulse start with A=5, B=5 at cycles 3 and 10 of CALC. Required: a single done pulse, Product=64'd6776, and the Product of the previous operation held until that done.
- Reset mid-operation: assert rst asynchronously (between clock edges) during CALC cycle 8. Required: busy=0, done=0, Product=0 immediately; no done follows. A new start of -111 * -2222 then gives 64'd246642.
- WIDTH=8 instance, signed: -128 * -128 gives 16'h4000, done 6 cycles after start. Unsigned: 255 * 255 gives 16'hFE01.

Source files
------------

// File: rtl/seq_booth_mul.sv
// Iterative radix-4 Booth multiplier, signed or unsigned, WIDTH x WIDTH -> 2*WIDTH.
// Latency ITER+1 cycles from accepted start to done; start is ignored unless IDLE.
module seq_booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      acc_hi_q, acc_hi_d;
  logic [XW-1:0]      mul_q, mul_d;
  logic [XW-1:0]      mcand_q, mcand_d;
  logic               booth_q, booth_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [XW+1:0]      mcand_x;
  logic [XW+1:0]      pp;
  logic [XW+1:0]      sum;
  logic [2*XW-1:0]    acc_next;

  // Upper half is summed two bits wider so +/-2M can never wrap before the shift.
  always_comb begin
    mcand_x = {{2{mcand_q[XW-1]}}, mcand_q};
    case ({mul_q[1:0], booth_q})
      3'b001, 3'b010: pp = mcand_x;
      3'b011:         pp = mcand_x << 1;
      3'b100:         pp = -(mcand_x << 1);
      3'b101, 3'b110: pp = -mcand_x;
      default:        pp = '0;
    endcase
    sum      = {{2{acc_hi_q[XW-1]}}, acc_hi_q} + pp;
    acc_next = {sum, mul_q[XW-1:2]};
  end

  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    mul_d     = mul_q;
    mcand_d   = mcand_q;
    booth_d   = booth_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{2{signed_mode & A[WIDTH-1]}}, A};
          mul_d    = {{2{signed_mode & B[WIDTH-1]}}, B};
          acc_hi_d = '0;
          booth_d  = 1'b0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // The multiplier register drains into the low half of the accumulator.
        acc_hi_d = acc_next[2*XW-1:XW];
        mul_d    = acc_next[XW-1:0];
        booth_d  = mul_q[1];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d   = DONE;
          product_d = acc_next[2*WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_hi_q  <= '0;
      mul_q     <= '0;
      mcand_q   <= '0;
      booth_q   <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      mul_q     <= mul_d;
      mcand_q   <= mcand_d;
      booth_q   <= booth_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// Bench for seq_booth_mul: 32-bit instance checked every cycle against a timing/arithmetic
// model, plus directed literal vectors on the 32-bit and 8-bit instances.
module tb_seq_booth_mul;

  localparam int ITER32 = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0, mode32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] prod32;
  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_booth_mul #(.WIDTH(32)) u_mul32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(mode32),
    .A(a32), .B(b32), .busy(busy32), .done(done32), .Product(prod32)
  );

  seq_booth_mul #(.WIDTH(8)) u_mul8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(mode8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .Product(prod8)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sm);
    longint      sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (sm) return 64'(sa * sb);
    return ua * ub;
  endfunction

  // Model: accepted op is busy ITER cycles, done in the next, idle one cycle after that.
  int          edge_n = 0;
  int          t_acc = 0;
  bit          active = 1'b0;
  logic [63:0] pend = '0;
  logic [63:0] exp_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      exp_prod <= '0;
    end else begin
      edge_n <= edge_n + 1;
      if (active && edge_n + 1 == t_acc + ITER32) exp_prod <= pend;
      if ((!active || edge_n + 1 > t_acc + ITER32 + 1) && start32) begin
        active <= 1'b1;
        t_acc  <= edge_n + 1;
        pend   <= ref_mul(a32, b32, mode32);
      end else if (active && edge_n + 1 > t_acc + ITER32) begin
        active <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(busy32), 64'(active && edge_n <= t_acc + ITER32 - 1));
    check("cyc_done", 64'(done32), 64'(active && edge_n == t_acc + ITER32));
    check("cyc_product", prod32, exp_prod);
  end

  // Issue one op; g1/g2 are CALC cycles in which a stray start (A=B=5) is pulsed.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [63:0] expv, input int g1, input int g2, input string nm);
    int cnt, nbusy;
    start32 = 1'b1; a32 = a; b32 = b; mode32 = sm;
    cnt = 0; nbusy = 0;
    do begin
      @(negedge clk);
      cnt++;
      nbusy += int'(busy32);
      start32 = (cnt == g1 || cnt == g2);
      if (start32) begin
        a32 = 32'd5; b32 = 32'd5;
      end else begin
        a32 = $urandom; b32 = $urandom; mode32 = 1'($urandom);
      end
    end while (!done32 && cnt < 60);
    start32 = 1'b0;
    check({nm, "_latency"}, 64'(cnt), 64'd18);
    check({nm, "_busy_cycles"}, 64'(nbusy), 64'd17);
    check({nm, "_product"}, prod32, expv);
    @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] expv, input string nm);
    int cnt;
    start8 = 1'b1; a8 = a; b8 = b; mode8 = sm;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      start8 = 1'b0;
    end while (!done8 && cnt < 30);
    check({nm, "_latency"}, 64'(cnt), 64'd6);
    check({nm, "_product"}, 64'(prod8), 64'(expv));
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_product32", prod32, 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_product8", 64'(prod8), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run32(32'd20, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFC4, 0, 0, "s20x-3");
    run32(-32'sd90, -32'sd90, 1'b1, 64'd8100, 0, 0, "b2b_m90xm90");
    run32(-32'sd100, 32'd99, 1'b1, 64'hFFFF_FFFF_FFFF_D954, 0, 0, "b2b_m100x99");
    run32(32'd0, 32'd98765, 1'b1, 64'd0, 0, 0, "b2b_0x98765");
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 0, "b2b_min_sq");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 0, "u_max_sq");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0, 0, "s_m1_sq");
    run32(32'd77, 32'd88, 1'b1, 64'd6776, 3, 10, "ignored_start");

    // Asynchronous reset in the middle of CALC cycle 8.
    start32 = 1'b1; a32 = 32'd1234; b32 = 32'd5678; mode32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_product", prod32, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      ndone += int'(done32);
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run32(-32'sd111, -32'sd2222, 1'b1, 64'd246642, 0, 0, "after_rst");

    run8(8'h80, 8'h80, 1'b1, 16'h4000, "w8_min_sq");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_u_max_sq");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
